// File: rtl/status_led_driver.sv
// status_led_driver: result-status FSM driving a PWM-dimmed, blinking, active-low RGB LED.
module status_led_driver #(
    parameter int PWM_BITS       = 8,
    parameter int BRIGHTNESS     = 32,
    parameter int BLINK_HALF     = 24000000,
    parameter int TIMEOUT_CYCLES = 96000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       result_valid,
    input  logic       result_ok,
    output logic       LED_R,
    output logic       LED_G,
    output logic       LED_B,
    output logic [1:0] state,
    output logic [7:0] pass_count,
    output logic [7:0] fail_count
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF - 1);
    localparam logic [PWM_BITS-1:0] BRI = PWM_BITS'(BRIGHTNESS);

    typedef enum logic [1:0] {IDLE, PASS, FAIL, STALL} state_t;

    state_t              st;
    logic [TW-1:0]       tmo;
    logic [BW-1:0]       bcnt;
    logic [PWM_BITS-1:0] pwm;
    logic                phase;
    logic                pwm_on;
    logic                gate;
    logic                r_sel;
    logic                g_sel;
    logic                b_sel;

    assign state = st;

    always_comb begin
        pwm_on = pwm < BRI;
        gate   = (st == FAIL || st == STALL) ? phase : 1'b1;
        r_sel  = st == FAIL;
        g_sel  = st == PASS;
        b_sel  = st == IDLE || st == STALL;
    end

    // A result on the expiry cycle wins over the stall transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else if (st != FAIL) begin
            st <= result_valid ? (result_ok ? PASS : FAIL) :
                  ((st == IDLE || st == PASS) && tmo == TMAX) ? STALL : st;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo        <= '0;
            bcnt       <= '0;
            pwm        <= '0;
            phase      <= 1'b1;
            pass_count <= '0;
            fail_count <= '0;
            LED_R      <= 1'b1;
            LED_G      <= 1'b1;
            LED_B      <= 1'b1;
        end else begin
            tmo        <= result_valid ? '0 : (tmo == TMAX ? tmo : tmo + 1'b1);
            bcnt       <= bcnt == BMAX ? '0 : bcnt + 1'b1;
            phase      <= bcnt == BMAX ? ~phase : phase;
            pwm        <= pwm + 1'b1;
            pass_count <= pass_count + 8'(result_valid && result_ok && pass_count != 8'hff);
            fail_count <= fail_count + 8'(result_valid && !result_ok && fail_count != 8'hff);
            LED_R      <= ~(r_sel & pwm_on & gate);
            LED_G      <= ~(g_sel & pwm_on & gate);
            LED_B      <= ~(b_sel & pwm_on & gate);
        end
    end
endmodule

// File: tb/tb_status_led_driver.sv
// tb_status_led_driver: directed scenarios for status_led_driver with small test parameters.
module tb_status_led_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       result_valid = 1'b0;
    logic       result_ok = 1'b0;
    logic       LED_R;
    logic       LED_G;
    logic       LED_B;
    logic [1:0] state;
    logic [7:0] pass_count;
    logic [7:0] fail_count;

    int checks = 0;
    int fails = 0;
    int n = 0;

    status_led_driver #(
        .PWM_BITS(4),
        .BRIGHTNESS(4),
        .BLINK_HALF(8),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .result_valid(result_valid),
        .result_ok(result_ok),
        .LED_R(LED_R),
        .LED_G(LED_G),
        .LED_B(LED_B),
        .state(state),
        .pass_count(pass_count),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // Expected {R,G,B} after edge k (edges counted from reset release), given the state before it.
    function automatic logic [2:0] led_exp(input logic [1:0] s, input int k);
        logic on;
        logic ph;
        on = ((k - 1) % 16) < 4;
        ph = (((k - 1) / 8) % 2) == 0;
        return ~{s == 2'd2 && on && ph, s == 2'd1 && on, on && (s == 2'd0 || (s == 2'd3 && ph))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic strobe(input logic ok);
        result_valid = 1'b1;
        result_ok = ok;
        tick();
        result_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state, LED_R, LED_G, LED_B} !== 5'b00111) begin
            fails++;
            $display("FAIL reset_outputs: state/RGB=%b required 00111", {state, LED_R, LED_G, LED_B});
        end
        checks++;
        if ({pass_count, fail_count} !== 16'h0) begin
            fails++;
            $display("FAIL reset_counts: got %0d/%0d required 0/0", pass_count, fail_count);
        end
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_idle();
        int lows = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            lows += (LED_B == 1'b0) ? 1 : 0;
            checks++;
            if ({LED_R, LED_G, LED_B} !== led_exp(2'd0, n)) begin
                fails++;
                $display("FAIL idle_led edge %0d: RGB=%b required %b", n, {LED_R, LED_G, LED_B}, led_exp(2'd0, n));
            end
        end
        checks++;
        if (state !== 2'd0 || lows != 4) begin
            fails++;
            $display("FAIL idle_summary: state=%0d blue_lows=%0d required 0 and 4", state, lows);
        end
    endtask

    task automatic test_pass();
        int lows = 0;
        strobe(1'b1);
        checks++;
        if (state !== 2'd1 || pass_count !== 8'd1) begin
            fails++;
            $display("FAIL pass_enter: state=%0d pass_count=%0d required 1 and 1", state, pass_count);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            lows += (LED_G == 1'b0) ? 1 : 0;
            checks++;
            if ({LED_R, LED_G, LED_B} !== led_exp(2'd1, n)) begin
                fails++;
                $display("FAIL pass_led edge %0d: RGB=%b required %b", n, {LED_R, LED_G, LED_B}, led_exp(2'd1, n));
            end
        end
        checks++;
        if (lows != 4) begin
            fails++;
            $display("FAIL pass_duty: green_lows=%0d required 4", lows);
        end
    endtask

    task automatic test_stall();
        strobe(1'b1);
        for (int i = 0; i < 19; i++) begin
            tick();
            checks++;
            if (state !== 2'd1) begin
                fails++;
                $display("FAIL stall_early cycle %0d: state=%0d required 1", i + 1, state);
            end
        end
        tick();
        checks++;
        if (state !== 2'd3) begin
            fails++;
            $display("FAIL stall_enter: state=%0d required 3", state);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({LED_R, LED_G, LED_B} !== led_exp(2'd3, n)) begin
                fails++;
                $display("FAIL stall_led edge %0d: RGB=%b required %b", n, {LED_R, LED_G, LED_B}, led_exp(2'd3, n));
            end
        end
        strobe(1'b1);
        checks++;
        if (state !== 2'd1 || pass_count !== 8'd3) begin
            fails++;
            $display("FAIL stall_recover: state=%0d pass_count=%0d required 1 and 3", state, pass_count);
        end
    endtask

    task automatic test_expiry_priority();
        for (int i = 0; i < 19; i++) tick();
        strobe(1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== 2'd1) begin
                fails++;
                $display("FAIL expiry_priority cycle %0d: state=%0d required 1", i, state);
            end
            tick();
        end
        checks++;
        if (pass_count !== 8'd4) begin
            fails++;
            $display("FAIL expiry_count: pass_count=%0d required 4", pass_count);
        end
    endtask

    task automatic test_fail();
        strobe(1'b0);
        checks++;
        if (state !== 2'd2 || fail_count !== 8'd1) begin
            fails++;
            $display("FAIL fail_enter: state=%0d fail_count=%0d required 2 and 1", state, fail_count);
        end
        strobe(1'b1);
        checks++;
        if (state !== 2'd2 || pass_count !== 8'd5) begin
            fails++;
            $display("FAIL fail_sticky: state=%0d pass_count=%0d required 2 and 5", state, pass_count);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if ({state, LED_R, LED_G, LED_B} !== {2'd2, led_exp(2'd2, n)}) begin
                fails++;
                $display("FAIL fail_led edge %0d: state/RGB=%b required %b", n, {state, LED_R, LED_G, LED_B}, {2'd2, led_exp(2'd2, n)});
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) strobe(1'b1);
        for (int i = 0; i < 260; i++) strobe(1'b0);
        checks++;
        if (pass_count !== 8'd255 || fail_count !== 8'd255 || state !== 2'd2) begin
            fails++;
            $display("FAIL saturate: pass=%0d fail=%0d state=%0d required 255 255 2", pass_count, fail_count, state);
        end
    endtask

    task automatic test_reset_midop();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state, LED_R, LED_G, LED_B} !== 5'b00111 || {pass_count, fail_count} !== 16'h0) begin
            fails++;
            $display("FAIL async_reset: state/RGB=%b counts=%0d/%0d required 00111 0/0", {state, LED_R, LED_G, LED_B}, pass_count, fail_count);
        end
        result_valid = 1'b1;
        result_ok = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 2'd0 || pass_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_ignores_valid: state=%0d pass_count=%0d required 0 and 0", state, pass_count);
        end
        result_valid = 1'b0;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            checks++;
            if ({state, LED_R, LED_G, LED_B} !== {2'd0, led_exp(2'd0, n)}) begin
                fails++;
                $display("FAIL post_reset edge %0d: state/RGB=%b required %b", n, {state, LED_R, LED_G, LED_B}, {2'd0, led_exp(2'd0, n)});
            end
        end
        tick();
        checks++;
        if (state !== 2'd3) begin
            fails++;
            $display("FAIL post_reset_stall: state=%0d required 3", state);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_pass();
        test_stall();
        test_expiry_priority();
        test_fail();
        test_saturate();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
